fastbconv_q_to_bba_seq: RTL and testbench

- Sequential fast base conversion of a vector of RNS integers from basis q to basis B∪Ba. It is the forward half of the BEHZ-style multiply: it extends q-residues into the B∪Ba domain, and fastBConvEx later converts them back from B∪Ba to q.
- Processes one q-prime per cycle across all N_SLOTS slots in parallel, accumulating into every B∪Ba residue.
- Output layout: B moduli occupy the first B_BASIS_LEN slots of each RNS integer, followed by the Ba modulus.

---
 rtl/fastbconv_q_to_bba_seq.sv | 183 ++++++++++++++++++
 tb/tb_fastbconv_q_to_bba_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fastbconv_q_to_bba_seq.sv
// Sequential fast base conversion q -> B u Ba: one q-prime per cycle, all slots in parallel.
// Optional macro FASTBCONV_QBBA_PIPE_EN registers y between the q-side and BBa-side multipliers.
module fastbconv_q_to_bba_seq #(
  parameter int unsigned N_SLOTS        = 2,
  parameter int unsigned RNS_PRIME_BITS = 8,
  parameter int unsigned IN_BASIS_LEN   = 3,
  parameter int unsigned OUT_BASIS_LEN  = 3,
  parameter int unsigned IN_BASIS     [IN_BASIS_LEN]  = '{13, 17, 19},
  parameter int unsigned OUT_BASIS    [OUT_BASIS_LEN] = '{23, 29, 31},
  parameter int unsigned QHATINV_LUT  [IN_BASIS_LEN]  = '{6, 2, 8},
  parameter int unsigned QHAT_MOD_OUT [IN_BASIS_LEN][OUT_BASIS_LEN] =
    '{'{1, 4, 13}, '{17, 15, 30}, '{14, 18, 4}}
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic [N_SLOTS-1:0][IN_BASIS_LEN-1:0][RNS_PRIME_BITS-1:0]  input_RNSpoly,
  output logic out_valid,
  output logic [N_SLOTS-1:0][OUT_BASIS_LEN-1:0][RNS_PRIME_BITS-1:0] output_RNSpoly
);

  localparam int W     = int'(RNS_PRIME_BITS);
  localparam int W2    = 2 * W;
  localparam int IDX_W = $clog2(IN_BASIS_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_BASIS_LEN - 1);
  localparam logic [IDX_W-1:0] LEN_IDX  = IDX_W'(IN_BASIS_LEN);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state, next_state;

  logic [IDX_W-1:0] idx;
  logic [N_SLOTS-1:0][IN_BASIS_LEN-1:0][W-1:0]  x_reg;
  logic [N_SLOTS-1:0][OUT_BASIS_LEN-1:0][W-1:0] acc;
  logic [N_SLOTS-1:0][OUT_BASIS_LEN-1:0][W-1:0] acc_next;
  logic [N_SLOTS-1:0][W-1:0] x_sel;
  logic [N_SLOTS-1:0][W-1:0] y_now;
  logic [N_SLOTS-1:0][W-1:0] term_y;
  logic [W-1:0]     q_sel;
  logic [W-1:0]     qinv_sel;
  logic [IDX_W-1:0] term_idx;
  logic             issue;
  logic             term_vld;
  logic             last_term;

  if (IN_BASIS_LEN == 0) begin : g_bad_len
    $fatal(1, "fastbconv_q_to_bba_seq: IN_BASIS_LEN must be at least 1");
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = ACCUM;
      ACCUM:   if (last_term) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // q-side constants and residues are picked by idx; an out-of-range idx selects a harmless modulus of 1
  always_comb begin
    q_sel    = W'(1);
    qinv_sel = '0;
    x_sel    = '0;
    for (int i = 0; i < int'(IN_BASIS_LEN); i++) begin
      if (idx == IDX_W'(i)) begin
        q_sel    = W'(IN_BASIS[i]);
        qinv_sel = W'(QHATINV_LUT[i]);
        for (int k = 0; k < int'(N_SLOTS); k++) begin
          x_sel[k] = x_reg[k][i];
        end
      end
    end
  end

  assign issue = (state == ACCUM) && (idx < LEN_IDX);

  for (genvar k = 0; k < int'(N_SLOTS); k++) begin : g_qside
    logic [W2-1:0] y_prod;
    assign y_prod   = W2'(x_sel[k]) * W2'(qinv_sel);
    assign y_now[k] = W'(y_prod % W2'(q_sel));
  end

`ifdef FASTBCONV_QBBA_PIPE_EN
  logic [N_SLOTS-1:0][W-1:0] y_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      vld_q;

  // The BBa side works one cycle behind the q side, carrying its own index and valid flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q   <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_now;
      idx_q <= idx;
      vld_q <= issue;
    end
  end

  assign term_y   = y_q;
  assign term_idx = idx_q;
  assign term_vld = vld_q;
`else
  assign term_y   = y_now;
  assign term_idx = idx;
  assign term_vld = issue;
`endif

  assign last_term = term_vld && (term_idx == LAST_IDX);

  for (genvar j = 0; j < int'(OUT_BASIS_LEN); j++) begin : g_bba
    localparam logic [W-1:0] M_W = W'(OUT_BASIS[j]);

    if (64'(OUT_BASIS[j]) >= (64'd1 << RNS_PRIME_BITS)) begin : g_bad_prime
      $fatal(1, "fastbconv_q_to_bba_seq: OUT_BASIS prime does not fit in RNS_PRIME_BITS");
    end

    logic [W-1:0] qhat_sel;

    always_comb begin
      qhat_sel = '0;
      for (int i = 0; i < int'(IN_BASIS_LEN); i++) begin
        if (term_idx == IDX_W'(i)) begin
          qhat_sel = W'(QHAT_MOD_OUT[i][j]);
        end
      end
    end

    for (genvar k = 0; k < int'(N_SLOTS); k++) begin : g_slot
      logic [W2-1:0] p_prod;
      logic [W-1:0]  p;
      logic [W:0]    sum;

      assign p_prod = W2'(term_y[k]) * W2'(qhat_sel);
      assign p      = W'(p_prod % W2'(M_W));
      assign sum    = {1'b0, acc[k][j]} + {1'b0, p};
      assign acc_next[k][j] = (sum >= {1'b0, M_W}) ? W'(sum - {1'b0, M_W}) : sum[W-1:0];
    end
  end

  // The result register is loaded with the final sum as DONE is entered, so it is valid with out_valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx            <= '0;
      x_reg          <= '0;
      acc            <= '0;
      output_RNSpoly <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg <= input_RNSpoly;
            acc   <= '0;
            idx   <= '0;
          end
        end
        ACCUM: begin
          if (idx < LEN_IDX) idx <= idx + IDX_W'(1);
          if (term_vld) acc <= acc_next;
          if (last_term) output_RNSpoly <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fastbconv_q_to_bba_seq.sv
// Scoreboard bench for fastbconv_q_to_bba_seq: random RNS vectors against a big-integer fastBConv model.
// Follows FASTBCONV_QBBA_PIPE_EN for the expected latency.
module tb_fastbconv_q_to_bba_seq;

  localparam int N = 2;
  localparam int L = 3;
  localparam int M_LEN = 3;
  localparam int W = 8;
`ifdef FASTBCONV_QBBA_PIPE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  localparam int unsigned Q_PRIMES [L]     = '{13, 17, 19};
  localparam int unsigned M_PRIMES [M_LEN] = '{23, 29, 31};

  typedef logic [N-1:0][L-1:0][W-1:0]     in_t;
  typedef logic [N-1:0][M_LEN-1:0][W-1:0] res_t;

  typedef struct {
    res_t data;
    int   due;
  } sb_item_t;

  logic clk;
  logic reset;
  logic in_valid;
  logic in_ready;
  in_t  input_RNSpoly;
  logic out_valid;
  res_t output_RNSpoly;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  sb_item_t exp_q[$];
  sb_item_t mon_item;

  fastbconv_q_to_bba_seq dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .input_RNSpoly(input_RNSpoly),
    .out_valid(out_valid),
    .output_RNSpoly(output_RNSpoly)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // fastBConv from its definition: sum_i ((x_i * (Q/q_i)^-1) mod q_i) * (Q/q_i), reduced mod m_j
  function automatic res_t golden(input in_t x);
    res_t r;
    longint unsigned big_q, qhat, inv, y, s;
    big_q = 1;
    for (int i = 0; i < L; i++) big_q = big_q * Q_PRIMES[i];
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < M_LEN; j++) begin
        s = 0;
        for (int i = 0; i < L; i++) begin
          qhat = big_q / Q_PRIMES[i];
          inv = 0;
          for (int v = 1; v < int'(Q_PRIMES[i]); v++) begin
            if (((qhat * longint'(v)) % Q_PRIMES[i]) == 1) inv = longint'(v);
          end
          y = (longint'(x[k][i]) * inv) % Q_PRIMES[i];
          s = s + y * qhat;
        end
        r[k][j] = W'(s % M_PRIMES[j]);
      end
    end
    return r;
  endfunction

  function automatic in_t rand_in();
    in_t x;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < L; i++)
        x[k][i] = W'($urandom_range(Q_PRIMES[i] - 1, 0));
    return x;
  endfunction

  task automatic checkOutput(input string name, input longint unsigned actual,
                             input longint unsigned expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Called at a negedge; drives the vector once in_ready is seen and records the expected result
  task automatic applyStimulus(input in_t x, input bit hold);
    int waited;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("accept_ready", in_ready, 1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    input_RNSpoly = x;
    in_valid = 1'b1;
    exp_q.push_back('{data: golden(x), due: cyc + 1 + L + EXTRA});
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out_valid", 1, 0);
      end else begin
        mon_item = exp_q.pop_front();
        checkOutput("result", output_RNSpoly, mon_item.data);
        checkOutput("latency", cyc, mon_item.due);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    in_t  x;
    res_t held;
    int   changes;

    reset = 1'b0;
    in_valid = 1'b0;
    input_RNSpoly = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_output", output_RNSpoly, 0);

    // All-zero vector with the busy window of in_ready
    applyStimulus('0, 1'b0);
    for (int n = 0; n <= L + EXTRA; n++) begin
      checkOutput("in_ready_busy", in_ready, 0);
      @(negedge clk);
    end
    checkOutput("in_ready_idle", in_ready, 1);
    drain();

    x = '0;
    for (int k = 0; k < N; k++) x[k][0] = W'(1);
    applyStimulus(x, 1'b0);
    drain();

    for (int k = 0; k < N; k++)
      for (int i = 0; i < L; i++)
        x[k][i] = W'(Q_PRIMES[i] - 1);
    applyStimulus(x, 1'b0);
    drain();

    // Back-to-back with in_valid held high
    for (int n = 0; n < 100; n++) applyStimulus(rand_in(), 1'b1);
    in_valid = 1'b0;
    drain();

    // A second request while busy must be ignored
    applyStimulus(rand_in(), 1'b0);
    input_RNSpoly = rand_in();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Asynchronous reset in the middle of ACCUM
    applyStimulus(rand_in(), 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_in_ready", in_ready, 1);
    checkOutput("midreset_output", output_RNSpoly, 0);
    exp_q.delete();
    #4 reset = 1'b1;
    repeat (L + 6) @(negedge clk);
    applyStimulus(rand_in(), 1'b0);
    drain();

    // Output must hold while idle
    held = output_RNSpoly;
    changes = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (output_RNSpoly !== held) changes++;
    end
    checkOutput("output_hold", changes, 0);
    checkOutput("hold_value", output_RNSpoly, held);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
